// File: rtl/fb_pkg.sv
// fb_pkg: frame-buffer geometry and fill-sequencer state type
package fb_pkg;
    localparam int ADDR_WIDTH = 15;
    localparam int H_RES = 160;
    localparam int V_RES = 120;
    localparam int FB_DEPTH = H_RES * V_RES;
    typedef enum logic {IDLE, CLEAR} fb_state_t;
endpackage

// File: rtl/fb_clear_seq.sv
// fb_clear_seq: full-frame fill sequencer emitting one ascending address per cycle
module fb_clear_seq #(
    parameter int ADDR_WIDTH = fb_pkg::ADDR_WIDTH,
    parameter int FB_DEPTH = fb_pkg::FB_DEPTH
) (
    input  logic                  clk_25,
    input  logic                  reset,
    input  logic                  clear_req,
    input  logic                  clear_pixel,
    output logic                  busy,
    output logic                  last,
    output logic [ADDR_WIDTH-1:0] count,
    output logic                  fill_pixel
);
    import fb_pkg::*;
    fb_state_t state, state_next;
    logic [ADDR_WIDTH-1:0] count_next;
    logic fill_pixel_next;
    assign busy = state == CLEAR;
    assign last = busy && count == ADDR_WIDTH'(FB_DEPTH - 1);
    always_ff @(posedge clk_25) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            fill_pixel <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            fill_pixel <= fill_pixel_next;
        end
    end
    always_comb begin
        state_next = state;
        count_next = count;
        fill_pixel_next = fill_pixel;
        if (!busy && clear_req) begin
            state_next = CLEAR;
            count_next = '0;
            fill_pixel_next = clear_pixel;
        end else if (busy) begin
            state_next = last ? IDLE : CLEAR;
            count_next = last ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin two-client frame-buffer write port with full-frame fill override
module fb_write_arbiter #(
    parameter int ADDR_WIDTH = fb_pkg::ADDR_WIDTH,
    parameter int FB_DEPTH = fb_pkg::FB_DEPTH
) (
    input  logic                  clk_25,
    input  logic                  reset,
    input  logic                  clear_req,
    input  logic                  clear_pixel,
    output logic                  clear_busy,
    output logic                  clear_done,
    input  logic                  c0_valid,
    input  logic [ADDR_WIDTH-1:0] c0_addr,
    input  logic                  c0_pixel,
    output logic                  c0_ready,
    input  logic                  c1_valid,
    input  logic [ADDR_WIDTH-1:0] c1_addr,
    input  logic                  c1_pixel,
    output logic                  c1_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic                  pixel,
    output logic                  addr_err
);
    logic fill_last, fill_pixel, open, rr_last, xfer, in_range, sel_pixel;
    logic [ADDR_WIDTH-1:0] fill_addr, sel_addr;
    fb_clear_seq #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .FB_DEPTH(FB_DEPTH)
    ) u_clear_seq (
        .clk_25(clk_25),
        .reset(reset),
        .clear_req(clear_req),
        .clear_pixel(clear_pixel),
        .busy(clear_busy),
        .last(fill_last),
        .count(fill_addr),
        .fill_pixel(fill_pixel)
    );
    // rr_last high means c1 was granted most recently, so c0 wins the next tie
    assign open = !clear_busy && !clear_req;
    assign c0_ready = open && c0_valid && (!c1_valid || rr_last);
    assign c1_ready = open && c1_valid && (!c0_valid || !rr_last);
    assign xfer = (c0_valid && c0_ready) || (c1_valid && c1_ready);
    assign sel_addr = c1_ready ? c1_addr : c0_addr;
    assign sel_pixel = c1_ready ? c1_pixel : c0_pixel;
    assign in_range = int'(sel_addr) < FB_DEPTH;
    always_ff @(posedge clk_25) begin
        if (reset) begin
            we <= 1'b0;
            write_addr <= '0;
            pixel <= 1'b0;
            clear_done <= 1'b0;
            addr_err <= 1'b0;
            rr_last <= 1'b1;
        end else begin
            we <= clear_busy || (xfer && in_range);
            clear_done <= fill_last;
            addr_err <= xfer && !in_range;
            if (clear_busy) begin
                write_addr <= fill_addr;
                pixel <= fill_pixel;
            end else if (xfer && in_range) begin
                write_addr <= sel_addr;
                pixel <= sel_pixel;
            end
            if (xfer) rr_last <= c1_ready;
        end
    end
endmodule
